fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 42 ++++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_sequencer.sv | 92 +++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
// Holds the RUN/HALT state type, buffer depth, default geometry and a pc wrap helper.
package fetch_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // Buffer between fetch and decode; count needs to represent 0..FIFO_DEPTH.
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = 2;

   localparam int unsigned DEFAULT_MEM_WORDS = 128;
   localparam int unsigned DEFAULT_RESET_PC  = 0;

   // Memory depth is a power of two, so the modulo is a mask.
   function automatic logic [31:0] wrap_pc(input logic [31:0] v, input int unsigned words);
      return v & (words - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory, redirect and decode-side signals of the fetch sequencer
// master: the sequencer (drives pc, out_*, halted); slave: memory/decode/branch side.
interface fetch_sequencer_if;

   logic [31:0] pc;
   logic [31:0] instr;
   logic        isdone;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        halted;

   modport master (
      output pc,
      input  instr,
      input  isdone,
      input  redirect,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output halted
   );

   modport slave (
      input  pc,
      output instr,
      output isdone,
      output redirect,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  halted
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry {pc, instr} buffer with push, pop and flush
// Ports: clk, rst_n (async, active low), push, pop, flush, din[63:0], dout[63:0] (oldest entry),
//        count (entries held).
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [63:0]      din,
   output logic [63:0]      dout,
   output logic [CNT_W-1:0] count
);

   logic [63:0] mem [FIFO_DEPTH];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        pop_ok;
   logic        push_ok;

   assign pop_ok  = pop && (count != '0);
   // A full buffer still accepts a push when the head leaves in the same cycle;
   // the write lands in the slot being vacated, so order is preserved.
   assign push_ok = push && ((count < CNT_W'(FIFO_DEPTH)) || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Payload needs no reset: it is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with 2-entry decode buffer
// Ports: clk, rst_n (async, active low), bus (fetch_sequencer_if.master): pc to memory,
//        instr/isdone from memory, redirect/redirect_pc from a later stage,
//        out_valid/out_ready/out_instr/out_pc towards decode, halted status.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
)
(
   input  logic               clk,
   input  logic               rst_n,
   fetch_sequencer_if.master  bus
);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [31:0]      pc_q;
   logic [31:0]      pc_nxt;
   logic [CNT_W-1:0] count;
   logic [63:0]      head;
   logic             valid_c;
   logic             pop_c;
   logic             fetch_c;
   logic             halted_c;
   logic [31:0]      out_instr_c;
   logic [31:0]      out_pc_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Next state: redirect always restarts fetching, even out of HALT.
   always_comb begin
      state_nxt = state;
      if (bus.redirect)
         state_nxt = ST_RUN;
      else if ((state == ST_RUN) && bus.isdone)
         state_nxt = ST_HALT;
   end

   // Outputs / per-cycle decisions
   always_comb begin
      valid_c     = (count != '0);
      pop_c       = valid_c && bus.out_ready;
      fetch_c     = (state == ST_RUN) && !bus.isdone && !bus.redirect &&
                    ((count < CNT_W'(FIFO_DEPTH)) || pop_c);
      halted_c    = (state == ST_HALT) && (count == '0);
      out_pc_c    = 32'd0;
      out_instr_c = 32'd0;
      if (valid_c) begin
         out_pc_c    = head[63:32];
         out_instr_c = head[31:0];
      end
   end

   always_comb begin
      pc_nxt = pc_q;
      if (bus.redirect)
         pc_nxt = wrap_pc(bus.redirect_pc, MEM_WORDS);
      else if (fetch_c)
         pc_nxt = wrap_pc(pc_q + 32'd1, MEM_WORDS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= 32'(RESET_PC);
      else        pc_q <= pc_nxt;
   end

   // Redirect flushes everything; a head handshaken in that cycle is simply
   // dropped with the rest, which is the same as having been consumed.
   fetch_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fetch_c),
      .pop   (pop_c),
      .flush (bus.redirect),
      .din   ({pc_q, bus.instr}),
      .dout  (head),
      .count (count)
   );

   assign bus.pc        = pc_q;
   assign bus.out_valid = valid_c;
   assign bus.out_instr = out_instr_c;
   assign bus.out_pc    = out_pc_c;
   assign bus.halted    = halted_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

   localparam int unsigned RST_PC = 0;
   localparam int unsigned WORDS  = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   fetch_sequencer_if bus();

   fetch_sequencer #(.RESET_PC(RST_PC), .MEM_WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem  [WORDS];
   logic        done [WORDS];

   assign bus.instr  = mem[bus.pc[6:0]];
   assign bus.isdone = done[bus.pc[6:0]];

   int          total = 0;
   int          bad   = 0;
   int          pops  = 0;
   logic [63:0] exp_q [$];
   logic [31:0] halt_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, expv);
      end
   endtask

   // Reference: from a start address the program is the run of consecutive
   // (wrapping) words up to, but excluding, the first end marker.
   task automatic build(input logic [31:0] start);
      int unsigned p;
      exp_q.delete();
      p = start % WORDS;
      for (int k = 0; k < int'(WORDS); k++) begin
         if (done[p]) break;
         exp_q.push_back({p, mem[p]});
         p = (p + 1) % WORDS;
      end
      halt_pc = p;
   endtask

   // Monitor: every presented head must be the oldest undelivered program word.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out actual_pc=%0h required=none", bus.out_pc);
         end else begin
            chk("out_pc", bus.out_pc, exp_q[0][63:32]);
            chk("out_instr", bus.out_instr, exp_q[0][31:0]);
            if (bus.out_ready) begin
               void'(exp_q.pop_front());
               pops++;
            end
         end
      end else begin
         chk("idle_out_pc", bus.out_pc, 32'd0);
         chk("idle_out_instr", bus.out_instr, 32'd0);
      end
      if (bus.halted && exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL halted_early actual_pending=%0d required=0", exp_q.size());
      end
   end

   // All tasks start and end at posedge+1.
   task automatic cyc(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         if (mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
         else           bus.out_ready = (mode == 1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_redirect(input logic [31:0] tgt);
      bus.redirect    = 1'b1;
      bus.redirect_pc = tgt;
      @(posedge clk);
      #1;
      bus.redirect    = 1'b0;
      build(tgt);
   endtask

   task automatic do_reset(input bit scramble);
      rst_n = 1'b0;
      #1;
      chk("rst_pc", bus.pc, RST_PC);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      if (scramble) begin
         for (int i = 0; i < int'(WORDS); i++) begin
            mem[i]  = $urandom();
            done[i] = ($urandom_range(0, 15) == 0);
         end
         done[$urandom_range(0, WORDS - 1)] = 1'b1;
      end
      build(RST_PC);
      pops = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_halt(input int bound);
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (!bus.halted && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("halt_reached", 32'(bus.halted), 32'd1);
      chk("halt_pc", bus.pc, halt_pc);
      chk("halt_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(WORDS); i++) begin
         mem[i]  = $urandom();
         done[i] = 1'b0;
      end
      done[4]  = 1'b1;
      done[40] = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.out_ready   = 1'b1;
      #2;

      // A,B,C,D back to back, then halted at the end marker.
      do_reset(1'b0);
      cyc(5, 1);
      chk("stream_halted", 32'(bus.halted), 32'd1);
      chk("stream_pc", bus.pc, 32'd4);
      chk("stream_pops", 32'(pops), 32'd4);

      // Backpressure from reset: buffer fills at two entries and holds A.
      do_reset(1'b0);
      cyc(5, 0);
      chk("bp_pc", bus.pc, 32'd2);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_head", bus.out_instr, mem[0]);
      cyc(2, 1);
      cyc(3, 0);

      // Redirect with a full buffer.
      do_redirect(32'd10);
      chk("redir_valid", 32'(bus.out_valid), 32'd0);
      chk("redir_pc", bus.pc, 32'd10);
      cyc(1, 0);
      chk("redir_pc_next", bus.pc, 32'd11);
      chk("redir_out_pc", bus.out_pc, 32'd10);
      wait_halt(100);

      // Restart out of HALT.
      do_redirect(32'd0);
      chk("unhalt", 32'(bus.halted), 32'd0);
      wait_halt(30);

      // Wrap at the top of memory.
      do_redirect(32'd127);
      cyc(1, 1);
      chk("wrap_127", bus.out_pc, 32'd127);
      cyc(1, 1);
      chk("wrap_0", bus.out_pc, 32'd0);
      cyc(1, 1);
      chk("wrap_1", bus.out_pc, 32'd1);
      wait_halt(30);

      // Reset with a full buffer.
      do_redirect(32'd20);
      cyc(4, 0);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      do_reset(1'b0);
      cyc(1, 1);
      chk("post_rst_first", bus.out_pc, RST_PC);
      wait_halt(30);

      // Random program, backpressure, redirects and resets.
      do_reset(1'b1);
      for (int it = 0; it < 40; it++) begin
         cyc($urandom_range(1, 25), 2);
         case ($urandom_range(0, 5))
            0:       wait_halt(300);
            1:       do_reset(1'b1);
            default: do_redirect($urandom());
         endcase
      end
      wait_halt(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
